axis_out_ctrl: RTL and testbench
================================

AXIS_OUT_CTRL -- requirements
Module: axis_out_ctrl

Interface
REQ-001 SHALL take parameter N, default `N, meaning characters per result frame.
REQ-002 SHALL take parameter CHAR_LEN, default `CHAR_LEN, meaning bits per character.
REQ-003 SHALL take parameter BATCH_SIZE, default `BATCH_SIZE, meaning frames per batch.
REQ-004 SHALL have port ACLK  in  1  clock.
REQ-005 SHALL have port ARESETN  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port soft_rst_n  in  1  synchronous clear, active-low; it is the rst_n bit of slv_reg0.
REQ-007 SHALL have port d  in  N*CHAR_LEN  result frame; character j is at bits [j*CHAR_LEN +: CHAR_LEN].
REQ-008 SHALL have port d_valid  in  1  core offers a frame.
REQ-009 SHALL have port d_ready  out  1  block accepts a frame.
REQ-010 SHALL have port M_AXIS_TDATA  out  CHAR_LEN  stream character.
REQ-011 SHALL have port M_AXIS_TVALID  out  1  stream valid.
REQ-012 SHALL have port M_AXIS_TLAST  out  1  last character of frame.
REQ-013 SHALL have port M_AXIS_TREADY  in  1  sink ready.
REQ-014 SHALL have port batch_done  out  1  one-cycle pulse after the BATCH_SIZE-th frame completes.

Function
REQ-015 SHALL implement FSM states IDLE and SEND.
REQ-016 In IDLE, SHALL drive d_ready=1 and TVALID=0.
- On d_valid&d_ready: capture d into frame buffer, set char index idx=0, go to SEND.
REQ-017 In SEND, SHALL drive d_ready=0, TVALID=1, TDATA=buffer char idx, TLAST=(idx==N-1).
REQ-018 SHALL treat a transfer as TVALID&TREADY on a rising ACLK edge.
- On a transfer: idx increments.
- On the transfer with idx==N-1: return to IDLE.
REQ-019 SHALL hold TDATA and TLAST stable while TVALID=1 and TREADY=0.
- SHALL never deassert TVALID before the transfer completes.
REQ-020 SHALL NOT make TVALID combinationally dependent on TREADY; all stream outputs are registered.
REQ-021 The first character SHALL appear on TDATA with TVALID=1 in the cycle after capture (latency 1).
REQ-022 With TREADY held at 1, a frame SHALL occupy exactly N consecutive cycles.
- One IDLE cycle follows before the next capture.
REQ-023 SHALL keep a frame counter of width $clog2(BATCH_SIZE+1).
- Increments on each last-character transfer.
- On reaching BATCH_SIZE: wraps to 0 and pulses batch_done for one cycle, in the cycle after the last transfer.
REQ-024 SHALL ignore d_valid during SEND; d is not sampled there.
REQ-025 When soft_rst_n=0 at an edge, SHALL force IDLE, idx=0, frame counter=0, TVALID=0, TLAST=0, batch_done=0.
- This overrides a simultaneous capture or transfer, including mid-frame.
REQ-026 With N=1, SHALL assert TLAST on the only character.

Reset
REQ-027 On ARESETN=0, SHALL asynchronously set: state IDLE, idx=0, frame counter=0, buffer=0.
- Outputs at reset: TDATA=0, TVALID=0, TLAST=0, batch_done=0, d_ready=1.
REQ-028 Reset release SHALL take effect on the next ACLK edge, with no spurious transfer.

Structure
REQ-029 N, CHAR_LEN and BATCH_SIZE SHALL come from the shared header consts_train.vh.
- FSM state encodings SHALL live in the same header.
REQ-030 SHALL be a single module with no sub-modules.
- The frame buffer is an N-entry register array indexed by idx.

Verification
REQ-031 Reset: ARESETN=0 for 2 cycles -> TVALID=0, TLAST=0, d_ready=1, batch_done=0.
REQ-032 Free flow: load frame chars 0x41,0x42,...; TREADY=1 -> N consecutive beats in order, TLAST only on beat N-1, d_ready=1 in the next cycle.
REQ-033 Backpressure: TREADY toggled 1,0,0,1,... -> TDATA and TLAST stable through stalls, no characters lost or duplicated.
REQ-034 Batch: BATCH_SIZE frames sent back-to-back -> exactly one batch_done pulse after the final TLAST transfer, and the counter returns to 0.
REQ-035 Mid-frame clear: soft_rst_n=0 at character 2 -> TVALID=0 next cycle; a new frame then starts from character 0.
REQ-036 Ignored input: d_valid=1 with new data during SEND -> output frame unchanged; the new frame is captured only once back in IDLE.

Source files
------------

// File: rtl/axis_out_ctrl_pkg.sv
// Shared training constants and FSM encodings for the result-stream output block.
// Every block built around the same training core takes its frame geometry from here.
package axis_out_ctrl_pkg;

  localparam int N_DEF          = 4;  // characters per result frame
  localparam int CHAR_LEN_DEF   = 8;  // bits per character
  localparam int BATCH_SIZE_DEF = 3;  // frames per batch

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // A one-character frame still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_out_ctrl.sv
// Serialises N-character result frames from the core onto an AXI-Stream master,
// one character per beat, and flags the end of every batch of frames.
module axis_out_ctrl
  import axis_out_ctrl_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int CHAR_LEN   = CHAR_LEN_DEF,
  parameter int BATCH_SIZE = BATCH_SIZE_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  soft_rst_n,
  input  logic [N*CHAR_LEN-1:0] d,
  input  logic                  d_valid,
  output logic                  d_ready,
  output logic [CHAR_LEN-1:0]   M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  batch_done
);

  localparam int IDX_W = idx_width(N);
  localparam int CNT_W = $clog2(BATCH_SIZE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH_SIZE - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_tvalid;
  logic                r_tlast;
  logic [CHAR_LEN-1:0] r_tdata;
  logic                r_batch_done;
  logic [CHAR_LEN-1:0] r_buf [N];

  state_t              w_state_next;
  logic [IDX_W-1:0]    w_idx_next;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_tvalid_next;
  logic                w_tlast_next;
  logic [CHAR_LEN-1:0] w_tdata_next;
  logic                w_batch_done_next;
  logic                w_capture;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_capture = soft_rst_n && (r_state == ST_IDLE) && d_valid;

  // Stream outputs are computed one cycle ahead so TVALID/TDATA/TLAST come straight from flops.
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_cnt_next        = r_cnt;
    w_tvalid_next     = r_tvalid;
    w_tlast_next      = r_tlast;
    w_tdata_next      = r_tdata;
    w_batch_done_next = 1'b0;
    if (!soft_rst_n) begin
      w_state_next  = ST_IDLE;
      w_idx_next    = '0;
      w_cnt_next    = '0;
      w_tvalid_next = 1'b0;
      w_tlast_next  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (d_valid) begin
            w_state_next  = ST_SEND;
            w_idx_next    = '0;
            w_tvalid_next = 1'b1;
            w_tdata_next  = d[0 +: CHAR_LEN];
            w_tlast_next  = (N == 1);
          end
        end
        ST_SEND: begin
          if (M_AXIS_TREADY) begin
            if (r_idx == LAST_IDX) begin
              w_state_next  = ST_IDLE;
              w_idx_next    = '0;
              w_tvalid_next = 1'b0;
              w_tlast_next  = 1'b0;
              if (r_cnt == LAST_CNT) begin
                w_cnt_next        = '0;
                w_batch_done_next = 1'b1;
              end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
              end
            end else begin
              w_idx_next   = w_idx_inc;
              w_tdata_next = r_buf[w_idx_inc];
              w_tlast_next = (w_idx_inc == LAST_IDX);
            end
          end
        end
        default: begin
          w_state_next  = ST_IDLE;
          w_idx_next    = '0;
          w_tvalid_next = 1'b0;
          w_tlast_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_batch_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cnt        <= w_cnt_next;
      r_tvalid     <= w_tvalid_next;
      r_tlast      <= w_tlast_next;
      r_tdata      <= w_tdata_next;
      r_batch_done <= w_batch_done_next;
    end
  end

  // Frame buffer: one register per character, loaded together at capture.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_buf
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          r_buf[gi] <= '0;
        end else if (w_capture) begin
          r_buf[gi] <= d[gi*CHAR_LEN +: CHAR_LEN];
        end
      end
    end
  endgenerate

  assign d_ready       = (r_state == ST_IDLE);
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;
  assign batch_done    = r_batch_done;

endmodule

// File: tb/tb_axis_out_ctrl.sv
// Directed self-checking bench for axis_out_ctrl with N=4, CHAR_LEN=8, BATCH_SIZE=3.
module tb_axis_out_ctrl;

  localparam int N  = 4;
  localparam int CL = 8;
  localparam int BS = 3;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic            soft_rst_n = 1'b1;
  logic [N*CL-1:0] d = '0;
  logic            d_valid = 1'b0;
  logic            d_ready;
  logic [CL-1:0]   M_AXIS_TDATA;
  logic            M_AXIS_TVALID;
  logic            M_AXIS_TLAST;
  logic            M_AXIS_TREADY = 1'b0;
  logic            batch_done;

  int checks = 0;
  int errors = 0;

  axis_out_ctrl #(.N(N), .CHAR_LEN(CL), .BATCH_SIZE(BS)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .soft_rst_n    (soft_rst_n),
    .d             (d),
    .d_valid       (d_valid),
    .d_ready       (d_ready),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .batch_done    (batch_done)
  );

  always #5 ACLK = ~ACLK;

  // Outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Frame whose character j is base+j.
  function automatic logic [N*CL-1:0] mk_frame(input logic [CL-1:0] base);
    logic [N*CL-1:0] f;
    f = '0;
    for (int j = 0; j < N; j++) f[j*CL +: CL] = base + CL'(j);
    return f;
  endfunction

  task automatic test_reset();
    ARESETN = 1'b0;
    tick();
    tick();
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", M_AXIS_TLAST); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready got %b want 1", d_ready); end
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL reset_batch_done got %b want 0", batch_done); end
    checks++; if (M_AXIS_TDATA !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", M_AXIS_TDATA); end
    ARESETN = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL release_tvalid got %b want 0", M_AXIS_TVALID); end
    $display("reset: done");
  endtask

  task automatic test_free_flow();
    d = mk_frame(8'h41);
    d_valid = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    d_valid = 1'b0;
    for (int b = 0; b < N; b++) begin
      checks++; if (M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL free_tvalid beat %0d got %b want 1", b, M_AXIS_TVALID); end
      checks++; if (M_AXIS_TDATA !== 8'h41 + 8'(b)) begin errors++; $display("FAIL free_tdata beat %0d got %h want %h", b, M_AXIS_TDATA, 8'h41 + 8'(b)); end
      checks++; if (M_AXIS_TLAST !== (b == N-1)) begin errors++; $display("FAIL free_tlast beat %0d got %b want %b", b, M_AXIS_TLAST, b == N-1); end
      checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL free_d_ready beat %0d got %b want 0", b, d_ready); end
      $display("free: beat %0d tdata=%h tlast=%b", b, M_AXIS_TDATA, M_AXIS_TLAST);
      tick();
    end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL free_end_tvalid got %b want 0", M_AXIS_TVALID); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL free_end_d_ready got %b want 1", d_ready); end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int exp_idx;
    int cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    d = mk_frame(8'h51);
    d_valid = 1'b1;
    M_AXIS_TREADY = 1'b0;
    tick();
    d_valid = 1'b0;
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < N && cyc < 40) begin
      checks++; if (M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL bp_tvalid cyc %0d got %b want 1", cyc, M_AXIS_TVALID); end
      checks++; if (M_AXIS_TDATA !== 8'h51 + 8'(exp_idx)) begin errors++; $display("FAIL bp_tdata cyc %0d got %h want %h", cyc, M_AXIS_TDATA, 8'h51 + 8'(exp_idx)); end
      checks++; if (M_AXIS_TLAST !== (exp_idx == N-1)) begin errors++; $display("FAIL bp_tlast cyc %0d got %b want %b", cyc, M_AXIS_TLAST, exp_idx == N-1); end
      M_AXIS_TREADY = pat[cyc % 4];
      $display("bp: cyc %0d tdata=%h tready=%b", cyc, M_AXIS_TDATA, M_AXIS_TREADY);
      tick();
      if (M_AXIS_TREADY) exp_idx++;
      cyc++;
    end
    checks++; if (exp_idx != N) begin errors++; $display("FAIL bp_timeout beats got %0d want %0d", exp_idx, N); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL bp_end_tvalid got %b want 0", M_AXIS_TVALID); end
    M_AXIS_TREADY = 1'b1;
  endtask

  task automatic test_batch();
    soft_rst_n = 1'b0;
    tick();
    soft_rst_n = 1'b1;
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL batch_clr_tvalid got %b want 0", M_AXIS_TVALID); end
    M_AXIS_TREADY = 1'b1;
    for (int f = 0; f < 2*BS; f++) begin
      d = mk_frame(8'(8'h10 * (f + 1)));
      d_valid = 1'b1;
      tick();
      d_valid = 1'b0;
      for (int b = 0; b < N; b++) begin
        checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL batch_early frame %0d beat %0d got %b want 0", f, b, batch_done); end
        tick();
      end
      checks++; if (batch_done !== ((f % BS) == BS-1)) begin errors++; $display("FAIL batch_pulse frame %0d got %b want %b", f, batch_done, (f % BS) == BS-1); end
      $display("batch: frame %0d batch_done=%b", f, batch_done);
    end
    tick();
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL batch_one_cycle got %b want 0", batch_done); end
  endtask

  task automatic test_mid_clear();
    d = mk_frame(8'h61);
    d_valid = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    d_valid = 1'b0;
    tick();
    tick();
    checks++; if (M_AXIS_TDATA !== 8'h63) begin errors++; $display("FAIL clr_at_char2 got %h want 63", M_AXIS_TDATA); end
    soft_rst_n = 1'b0;
    tick();
    soft_rst_n = 1'b1;
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL clr_tvalid got %b want 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL clr_tlast got %b want 0", M_AXIS_TLAST); end
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL clr_d_ready got %b want 1", d_ready); end
    d = mk_frame(8'h71);
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    for (int b = 0; b < N; b++) begin
      checks++; if (M_AXIS_TDATA !== 8'h71 + 8'(b) || M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL clr_new_frame beat %0d got %h/%b want %h/1", b, M_AXIS_TDATA, M_AXIS_TVALID, 8'h71 + 8'(b)); end
      $display("clear: new beat %0d tdata=%h", b, M_AXIS_TDATA);
      tick();
    end
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL clr_batch_done got %b want 0", batch_done); end
  endtask

  task automatic test_ignore();
    d = mk_frame(8'h81);
    d_valid = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    d = mk_frame(8'h91);
    for (int b = 0; b < N; b++) begin
      checks++; if (M_AXIS_TDATA !== 8'h81 + 8'(b)) begin errors++; $display("FAIL ign_tdata beat %0d got %h want %h", b, M_AXIS_TDATA, 8'h81 + 8'(b)); end
      $display("ignore: beat %0d tdata=%h", b, M_AXIS_TDATA);
      tick();
    end
    checks++; if (d_ready !== 1'b1 || M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL ign_idle got d_ready=%b tvalid=%b want 1/0", d_ready, M_AXIS_TVALID); end
    tick();
    d_valid = 1'b0;
    checks++; if (M_AXIS_TDATA !== 8'h91 || M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL ign_next_capture got %h/%b want 91/1", M_AXIS_TDATA, M_AXIS_TVALID); end
    for (int b = 0; b < N; b++) tick();
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL ign_drain got %b want 0", M_AXIS_TVALID); end
  endtask

  initial begin
    #2;
    test_reset();
    test_free_flow();
    test_backpressure();
    test_batch();
    test_mid_clear();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
